tx_framer: RTL and testbench
============================

TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker, first byte of every frame, SHALL be exposed.
REQ-002 Port clk, input, 1: single clock domain; all state updates on rising edge.
REQ-003 Port reset, input, 1: reset is synchronous and active-high.
REQ-004 Port s_data, input, 16: signed filter output sample, two's complement.
REQ-005 Port s_valid, input, 1: s_data valid; upstream holds s_data/s_valid stable until accepted.
REQ-006 Port s_ready, output, 1: framer can accept a sample this cycle.
REQ-007 Port tx_full, input, 1: UART transmit FIFO full flag.
REQ-008 Port wr_uart, output, 1: one-cycle write strobe into UART transmit FIFO.
REQ-009 Port w_data, output, 8: byte presented with wr_uart.
REQ-010 Port busy, output, 1: high while a frame is in progress.
REQ-011 Port frame_cnt, output, 8: count of completed frames, wraps.

Function
REQ-012 Frame format SHALL be 4 bytes in order: SYNC_BYTE, sample[15:8], sample[7:0], CSUM, where CSUM = SYNC_BYTE ^ sample[15:8] ^ sample[7:0].
REQ-013 FSM SHALL have states IDLE, SYNC, MSB, LSB, CSUM.
REQ-014 s_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE).
REQ-015 In IDLE, s_valid && s_ready at a clock edge SHALL capture s_data into an internal register and move to SYNC; otherwise stay in IDLE.
REQ-016 In SYNC/MSB/LSB/CSUM, wr_uart SHALL be combinationally !tx_full, with w_data the byte of that state; on edge with !tx_full, advance SYNC->MSB->LSB->CSUM->IDLE.
REQ-017 With tx_full high, the FSM SHALL hold state, keep wr_uart low and never drop or repeat a byte; on tx_full falling, resume with the held byte.
REQ-018 In IDLE, wr_uart SHALL be 0 and w_data SHALL be 8'h00.
REQ-019 Exactly one wr_uart pulse per byte; exactly 4 pulses per accepted sample.
REQ-020 Minimum latency: sample accepted at edge N; SYNC written in cycle N+1, CSUM in N+4, s_ready high again in cycle N+5.
REQ-021 frame_cnt SHALL increment by 1 at the edge that writes CSUM, wrapping 8'hFF -> 8'h00.
REQ-022 s_valid asserted while busy SHALL be ignored (not captured) and SHALL not disturb the frame in progress.
REQ-023 Capture register SHALL remain constant from acceptance until return to IDLE, independent of s_data changes.

Reset
REQ-024 reset at any clock edge SHALL force state IDLE, frame_cnt 0, capture register 0; outputs thereafter: s_ready 1, busy 0, wr_uart 0, w_data 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no further writes and no frame_cnt increment; reset has priority over all other events.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (5 states, 3 bits), the default SYNC_BYTE constant and the frame length constant 4.
REQ-027 Single module, no sub-module; checksum is a 3-input XOR in-line.

Verification
REQ-028 Reset, s_data 16'h1234 pulsed valid, tx_full 0 -> w_data A5,12,34,83 on 4 consecutive wr_uart cycles, frame_cnt 1, s_ready back in cycle N+5.
REQ-029 s_data 16'h8000, tx_full held high 3 cycles during MSB -> sequence A5,80,00,25, no wr_uart while full, no byte lost or duplicated.
REQ-030 s_valid held high with changing s_data during a frame -> only the first sample framed; next sample accepted only once s_ready high.
REQ-031 reset asserted in LSB state -> wr_uart 0 from next cycle, frame_cnt 0, s_ready 1, next sample 16'hFFFF framed A5,FF,FF,A5.
REQ-032 256 back-to-back samples 16'h0000 -> 1024 writes, each frame A5,00,00,A5, frame_cnt wraps to 0.

Source files
------------

// File: rtl/tx_framer_pkg.sv
// rtl/tx_framer_pkg.sv - shared constants and FSM encoding for the sample framer
package tx_framer_pkg;

    // One state per output byte plus the idle/accept state
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_MSB  = 3'd2,
        ST_LSB  = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN         = 4;

endpackage

// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - packs 16-bit samples into 4-byte sync/data/checksum UART frames
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    state_e      state_q, state_d;
    logic [15:0] sample_q, sample_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    assign s_ready   = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign frame_cnt = frame_cnt_q;

    // Next-state and byte output: each byte state strobes whenever the FIFO has room
    // and only advances on that same condition, so a full FIFO stalls on the held byte.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        frame_cnt_d = frame_cnt_q;
        wr_uart     = 1'b0;
        w_data      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    sample_d = s_data;
                    state_d  = ST_SYNC;
                end
            end
            ST_SYNC: begin
                w_data  = SYNC_BYTE;
                wr_uart = !tx_full;
                if (!tx_full) state_d = ST_MSB;
            end
            ST_MSB: begin
                w_data  = sample_q[15:8];
                wr_uart = !tx_full;
                if (!tx_full) state_d = ST_LSB;
            end
            ST_LSB: begin
                w_data  = sample_q[7:0];
                wr_uart = !tx_full;
                if (!tx_full) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                w_data  = SYNC_BYTE ^ sample_q[15:8] ^ sample_q[7:0];
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured sample and frame counter; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sample_q    <= 16'h0000;
            frame_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// tb/tb_tx_framer.sv - self-checking bench for tx_framer against a byte-level frame model
module tb_tx_framer;
    import tx_framer_pkg::*;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic [7:0]  frame_cnt;

    int tests_run;
    int tests_failed;

    // reference model state
    int          m_left;
    int          m_cnt;
    logic [15:0] m_sample;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          rdy_err;
    int          full_err;

    tx_framer #(.SYNC_BYTE(SYNC)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte capture from the UART side; a strobe during reset never lands
    always @(negedge clk) begin
        if (wr_uart === 1'b1 && reset === 1'b0) obs_q.push_back(w_data);
    end

    function automatic logic [7:0] frame_byte(input logic [15:0] smp, input int idx);
        case (idx)
            0:       return SYNC;
            1:       return smp[15:8];
            2:       return smp[7:0];
            default: return SYNC ^ smp[15:8] ^ smp[7:0];
        endcase
    endfunction

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // one clock: protocol sanity stats, model update from the inputs seen at the edge
    task automatic step();
        #3;
        if (s_ready !== (m_left == 0)) rdy_err++;
        if (busy !== (m_left != 0)) rdy_err++;
        if (wr_uart === 1'b1 && tx_full) full_err++;
        if (reset) begin
            m_left = 0;
            m_cnt  = 0;
        end else if (m_left == 0) begin
            if (s_valid) begin
                m_sample = s_data;
                m_left   = FRAME_LEN;
            end
        end else if (!tx_full) begin
            exp_q.push_back(frame_byte(m_sample, FRAME_LEN - m_left));
            m_left--;
            if (m_left == 0) m_cnt = (m_cnt + 1) % 256;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        reset   = 1'b1;
        s_valid = 1'b0;
        tx_full = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        rdy_err  = 0;
        full_err = 0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        tx_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        m_left  = 0;
        m_cnt   = 0;
        #1;
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: s_ready=%b busy=%b want 1 0", s_ready, busy);
        end
        tests_run++;
        if (wr_uart !== 1'b0 || w_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_write: wr_uart=%b w_data=%h want 0 00", wr_uart, w_data);
        end
        tests_run++;
        if (frame_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %h want 00", frame_cnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] lit [4];
        lit = '{8'hA5, 8'h12, 8'h34, 8'h83};
        reset_all();
        s_data  = 16'h1234;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_data  = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (wr_uart !== 1'b1 || w_data !== lit[i] || s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: wr_uart=%b w_data=%h s_ready=%b want 1 %h 0",
                         i, wr_uart, w_data, s_ready, lit[i]);
            end
            step();
        end
        #1;
        tests_run++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || wr_uart !== 1'b0 || w_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL basic_idle_n5: s_ready=%b busy=%b wr_uart=%b w_data=%h want 1 0 0 00",
                     s_ready, busy, wr_uart, w_data);
        end
        tests_run++;
        if (frame_cnt !== 8'h01) begin
            tests_failed++;
            $display("FAIL basic_cnt: got %h want 01", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] lit [4];
        lit = '{8'hA5, 8'h80, 8'h00, 8'h25};
        reset_all();
        s_data  = 16'h8000;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (wr_uart !== 1'b0 || w_data !== 8'h80) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: wr_uart=%b w_data=%h want 0 80", i, wr_uart, w_data);
            end
            step();
        end
        tx_full = 1'b0;
        repeat (4) step();
        tests_run++;
        if (obs_q.size() != 4) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d writes want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (obs_q[i] !== lit[i]) begin
                    tests_failed++;
                    $display("FAIL bp_byte%0d: got %h want %h", i, obs_q[i], lit[i]);
                end
            end
        end
        tests_run++;
        if (full_err != 0 || rdy_err != 0) begin
            tests_failed++;
            $display("FAIL bp_protocol: full_err=%0d rdy_err=%0d want 0 0", full_err, rdy_err);
        end
    endtask

    task automatic test_hold_valid();
        int d;
        reset_all();
        s_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_data = 16'($urandom);
            step();
        end
        s_valid = 1'b0;
        step();
        d = first_diff();
        tests_run++;
        if (d != -1 || obs_q.size() != 24) begin
            tests_failed++;
            $display("FAIL hold_valid_stream: diff_at=%0d writes=%0d want -1 24", d, obs_q.size());
        end
        tests_run++;
        if (frame_cnt !== 8'd6 || rdy_err != 0) begin
            tests_failed++;
            $display("FAIL hold_valid_cnt: cnt=%0d rdy_err=%0d want 6 0", frame_cnt, rdy_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] lit [4];
        lit = '{8'hA5, 8'hFF, 8'hFF, 8'hA5};
        reset_all();
        s_data  = 16'h1234;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if (wr_uart !== 1'b0 || frame_cnt !== 8'h00 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_state: wr_uart=%b cnt=%h s_ready=%b want 0 00 1",
                     wr_uart, frame_cnt, s_ready);
        end
        repeat (3) step();
        tests_run++;
        if (obs_q.size() != 2) begin
            tests_failed++;
            $display("FAIL midreset_writes: got %0d writes want 2", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
        s_data  = 16'hFFFF;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (5) step();
        tests_run++;
        if (obs_q.size() != 4) begin
            tests_failed++;
            $display("FAIL midreset_next_count: got %0d writes want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (obs_q[i] !== lit[i]) begin
                    tests_failed++;
                    $display("FAIL midreset_next_byte%0d: got %h want %h", i, obs_q[i], lit[i]);
                end
            end
        end
        tests_run++;
        if (frame_cnt !== 8'h01) begin
            tests_failed++;
            $display("FAIL midreset_next_cnt: got %h want 01", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lit [4];
        int bad;
        lit = '{8'hA5, 8'h00, 8'h00, 8'hA5};
        reset_all();
        s_data  = 16'h0000;
        s_valid = 1'b1;
        repeat (1275) step();
        #1;
        tests_run++;
        if (frame_cnt !== 8'hFF) begin
            tests_failed++;
            $display("FAIL b2b_cnt255: got %h want ff", frame_cnt);
        end
        repeat (5) step();
        s_valid = 1'b0;
        step();
        bad = 0;
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i] !== lit[i % 4]) bad++;
        tests_run++;
        if (obs_q.size() != 1024 || bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_stream: writes=%0d bad=%0d want 1024 0", obs_q.size(), bad);
        end
        tests_run++;
        if (frame_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL b2b_wrap: got %h want 00", frame_cnt);
        end
    endtask

    task automatic test_random();
        int d;
        reset_all();
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom % 3) != 0;
            s_data  = 16'($urandom);
            tx_full = ($urandom % 4) == 0;
            step();
        end
        s_valid = 1'b0;
        tx_full = 1'b0;
        repeat (6) step();
        d = first_diff();
        tests_run++;
        if (d != -1) begin
            tests_failed++;
            $display("FAIL random_stream: diff_at=%0d writes=%0d expected_writes=%0d",
                     d, obs_q.size(), exp_q.size());
        end
        tests_run++;
        if (frame_cnt !== 8'(m_cnt)) begin
            tests_failed++;
            $display("FAIL random_cnt: got %0d want %0d", frame_cnt, m_cnt);
        end
        tests_run++;
        if (rdy_err != 0 || full_err != 0) begin
            tests_failed++;
            $display("FAIL random_protocol: rdy_err=%0d full_err=%0d want 0 0", rdy_err, full_err);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_left       = 0;
        m_cnt        = 0;
        m_sample     = 16'h0000;
        rdy_err      = 0;
        full_err     = 0;
        reset        = 1'b1;
        s_valid      = 1'b0;
        s_data       = 16'h0000;
        tx_full      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_hold_valid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
